cnn_cntr_gen: RTL
=================

# cnn_cntr_gen

Command generator driving the CNN PE array's control-packet input. Accepts a job configuration, streams weight words into each output-channel PE buffer, then issues per-cycle read-address/PE-state commands that sequence multiply, adder tree and accumulation for every activation pass. It is the initiator whose `CNTR_PACKET` output feeds the packet decoder in front of the OCP_NUM PE lanes.

## Interface
- `DATA_WID`, default `CNN_XLEN`: bits per weight/activation word
- `ICP_NUM`, default `ICP_NUM`: words per buffer entry (input channels)
- `OCP_NUM`, default `OCP_NUM`: PE lanes (output channels)
- `ADDR_B`, default `ADDR_B`: weight-buffer address width
- `NPASS_B`, default 16: pass-counter width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle job request; sampled only in IDLE
- `cfg_len`  in  ADDR_B+1  kernel length (entries per lane), legal 2..2^ADDR_B
- `cfg_npass`  in  NPASS_B  activation passes to run
- `cfg_reuse`  in  1  1 = skip LOAD, reuse resident weights
- `w_valid`  in  1  weight beat valid
- `w_ready`  out  1  weight beat accepted when both high
- `w_data`  in  ICP_NUM×DATA_WID  one buffer entry
- `a_valid`  in  1  activation beat available upstream
- `a_ready`  out  1  activation beat consumed when both high
- `CNN_pk_out`  out  CNTR_PACKET  registered command to decoder
- `busy`  out  1  high from accepted start to DONE
- `done`  out  1  one-cycle pulse at job end
- `cfg_err`  out  1  one-cycle pulse on rejected start

## Operation
- FSM: IDLE, LOAD, COMPUTE, DONE.
- IDLE: on `start`, latch cfg. If `cfg_len` < 2 or > 2^ADDR_B: pulse `cfg_err`, stay IDLE. Else go LOAD (or COMPUTE if `cfg_reuse`). `start` outside IDLE ignored.
- LOAD: `w_ready`=1. Each accepted beat writes lane `lane`, address `addr`: next-cycle packet wrb = one-hot(lane), wrb_addr = addr, wrb_data = w_data, PE_state = PE_IDLE. `addr` increments; at `cfg_len`-1 wraps to 0 and `lane` increments. After lane OCP_NUM-1 / addr `cfg_len`-1 go COMPUTE. No beat: wrb = 0.
- COMPUTE: `a_ready`=1. Each accepted beat issues rdb_addr = addr and PE_state = PE_FIRST (addr 0), PE_LAST (addr `cfg_len`-1), PE_ACC otherwise; wrb = 0. Wrap of addr increments pass counter; after pass `cfg_npass`-1 go DONE. `cfg_npass`=0: go DONE directly from entry. No beat (a_valid low): PE_state = PE_IDLE, rdb_addr held.
- DONE: pulse `done`, drop `busy`, return IDLE next cycle.
- Packet fields not named above are driven 0.

## Timing
- Reset (async, any state): FSM IDLE, counters 0, `CNN_pk_out` all-zero (PE_IDLE = 0), `w_ready`/`a_ready`/`busy`/`done`/`cfg_err` = 0. Reset mid-job discards it; no partial packet emitted.
- `w_ready`/`a_ready` are functions of registered state only (no valid→ready path).
- Packet latency: handshake at cycle t → `CNN_pk_out` at t+1. Activation data bypasses this block; caller delays A to match decoder latency.
- `busy` high from cycle after accepted `start` through last COMPUTE packet; `done` coincides with DONE state.
- Minimum job: OCP_NUM·len load beats + npass·len compute beats + 2 cycles (IDLE→, DONE).
- Back-to-back: `start` in the IDLE cycle after DONE accepted.

## Structure
- Shared package: `CNTR_PACKET` (PE_state, wrb_data, wrb_addr, wrb[OCP_NUM], rdb_addr), `PE_STATE` enum (PE_IDLE=0, PE_FIRST, PE_ACC, PE_LAST), FSM state enum.
- One sub-module: `cntr_addr_seq` — addr counter with programmable wrap and outer counter (lane/pass), reporting `wrap` and `last`.

## Test plan
(OCP_NUM=4, ICP_NUM=4, ADDR_B=4)
- len=3, npass=2, reuse=0, valids held high → 12 write packets wrb 0001,0001,0001,0010…1000 addr 0,1,2 repeating; then states FIRST,ACC,LAST,FIRST,ACC,LAST rdb 0,1,2,0,1,2; `done` after; total 20 cycles from start.
- Same job, w_valid toggled 1/0 → wrb=0 on gaps, sequence unchanged, LOAD twice as long.
- reuse=1, len=2, npass=3, a_valid low 2 cycles mid-pass → no write packets; PE_IDLE inserted 2 cycles, rdb_addr held; 6 compute packets.
- start with len=1 and len=17 → `cfg_err` pulse each, `busy` stays 0, packet stays zero.
- reset low during COMPUTE pass 1 → outputs zero immediately; after release, new start runs full job normally.
- start pulsed while busy → ignored; npass=0 → DONE right after LOAD, no compute packets.

Source files
------------

// File: rtl/cnn_cntr_gen_pkg.sv
// Shared types for the CNN command generator: the control packet sent to
// the PE-array decoder, the per-PE operation code and the generator FSM state.
package cnn_cntr_gen_pkg;

  // Array geometry shared by the generator and the packet decoder.
  localparam int CNN_XLEN    = 8;   // bits per weight/activation word
  localparam int CNN_ICP_NUM = 4;   // words per buffer entry (input channels)
  localparam int CNN_OCP_NUM = 4;   // PE lanes (output channels)
  localparam int CNN_ADDR_B  = 4;   // weight-buffer address width
  localparam int CNN_NPASS_B = 16;  // pass-counter width

  // Longest legal kernel: one entry per buffer address.
  localparam logic [CNN_ADDR_B:0] CNN_LEN_MAX = {1'b1, {CNN_ADDR_B{1'b0}}};
  localparam logic [CNN_ADDR_B:0] CNN_LEN_MIN = (CNN_ADDR_B + 1)'(2);

  // What each PE does with the word read this cycle.
  typedef enum logic [1:0] {
    PE_IDLE  = 2'd0,  // nothing issued
    PE_FIRST = 2'd1,  // first entry of a kernel: restart accumulation
    PE_ACC   = 2'd2,  // middle entry: accumulate
    PE_LAST  = 2'd3   // final entry: accumulate and retire the result
  } PE_STATE;

  // Generator FSM state, also exported for debug visibility.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } cntr_state_e;

  // Command word presented to the decoder every cycle.
  typedef struct packed {
    PE_STATE                          PE_state;
    logic [CNN_ICP_NUM*CNN_XLEN-1:0]  wrb_data;
    logic [CNN_ADDR_B-1:0]            wrb_addr;
    logic [CNN_OCP_NUM-1:0]           wrb;
    logic [CNN_ADDR_B-1:0]            rdb_addr;
  } CNTR_PACKET;

  // A kernel must have at least a FIRST and a LAST entry and must fit the buffer.
  function automatic logic len_ok(input logic [CNN_ADDR_B:0] len);
    return (len >= CNN_LEN_MIN) && (len <= CNN_LEN_MAX);
  endfunction

endpackage

// File: rtl/cntr_addr_seq.sv
// Two-level address sequencer: an inner address counter that wraps at a
// programmable length and an outer counter (lane during weight load, pass
// during compute) that advances on every inner wrap.
module cntr_addr_seq #(
  parameter int ADDR_B = 4,
  parameter int OUT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,         // restart both counters at zero
  input  logic              inc_i,         // advance by one entry
  input  logic [ADDR_B:0]   len_i,         // inner wrap length (2..2^ADDR_B)
  input  logic [OUT_W-1:0]  outer_last_i,  // final outer value
  output logic [ADDR_B-1:0] addr_o,
  output logic [OUT_W-1:0]  outer_o,
  output logic              addr_last_o,   // address sits on len-1
  output logic              wrap_o,        // this increment wraps the address
  output logic              last_o         // outer counter is on its final value
);

  logic [ADDR_B-1:0] addr_q, addr_d;
  logic [OUT_W-1:0]  outer_q, outer_d;
  logic [ADDR_B:0]   len_m1;

  assign len_m1      = len_i - (ADDR_B + 1)'(1);
  assign addr_last_o = ({1'b0, addr_q} == len_m1);
  assign wrap_o      = inc_i & addr_last_o;
  assign last_o      = (outer_q == outer_last_i);
  assign addr_o      = addr_q;
  assign outer_o     = outer_q;

  // Next count: the outer counter folds back to zero after its final value so
  // the sequencer is ready for the next phase without an explicit clear.
  always_comb begin
    addr_d  = addr_q;
    outer_d = outer_q;
    if (clr_i) begin
      addr_d  = '0;
      outer_d = '0;
    end else if (inc_i) begin
      if (addr_last_o) begin
        addr_d  = '0;
        outer_d = last_o ? '0 : outer_q + OUT_W'(1);
      end else begin
        addr_d  = addr_q + ADDR_B'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      outer_q <= '0;
    end else begin
      addr_q  <= addr_d;
      outer_q <= outer_d;
    end
  end

endmodule

// File: rtl/cnn_cntr_gen.sv
// CNN command generator. Takes a job configuration, streams weight entries
// into every output-channel PE buffer, then issues one read/PE-state command
// per accepted activation beat for each pass. The packet type is fixed by
// cnn_cntr_gen_pkg, so the geometry parameters must keep their defaults.
//
// Handshakes: a beat transfers on a rising clock edge where valid and ready
// are both high. Ready depends only on registered FSM state (never on valid);
// valid may rise or fall freely and nothing is transferred while it is low.
module cnn_cntr_gen
  import cnn_cntr_gen_pkg::*;
#(
  parameter int DATA_WID = CNN_XLEN,
  parameter int ICP_NUM  = CNN_ICP_NUM,
  parameter int OCP_NUM  = CNN_OCP_NUM,
  parameter int ADDR_B   = CNN_ADDR_B,
  parameter int NPASS_B  = CNN_NPASS_B
) (
  input  logic                        clk,
  input  logic                        reset,      // asynchronous, active low
  input  logic                        start,
  input  logic [ADDR_B:0]             cfg_len,
  input  logic [NPASS_B-1:0]          cfg_npass,
  input  logic                        cfg_reuse,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [ICP_NUM*DATA_WID-1:0] w_data,
  input  logic                        a_valid,
  output logic                        a_ready,
  output CNTR_PACKET                  CNN_pk_out,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err,
  output cntr_state_e                 dbg_state
);

  localparam logic [OCP_NUM-1:0] LANE0     = OCP_NUM'(1);
  localparam logic [NPASS_B-1:0] LANE_LAST = NPASS_B'(OCP_NUM - 1);

  cntr_state_e       state_q, state_d;
  logic [ADDR_B:0]   len_q;
  logic [NPASS_B-1:0] npass_q;
  logic              w_ready_q, a_ready_q, busy_q, done_q, cfg_err_q;
  CNTR_PACKET        pk_q, pk_d;

  logic              idle_start, len_good;
  logic              w_beat, a_beat;
  logic [ADDR_B-1:0] seq_addr;
  logic [NPASS_B-1:0] seq_outer, outer_last;
  logic              seq_addr_last, seq_wrap, seq_last;

  assign idle_start = (state_q == ST_IDLE) && start;
  assign len_good   = len_ok(cfg_len);
  assign w_beat     = w_valid & w_ready_q;
  assign a_beat     = a_valid & a_ready_q;

  // Lanes are counted while loading, passes while computing.
  assign outer_last = (state_q == ST_LOAD) ? LANE_LAST : (npass_q - NPASS_B'(1));

  cntr_addr_seq #(
    .ADDR_B (ADDR_B),
    .OUT_W  (NPASS_B)
  ) u_seq (
    .clk_i        (clk),
    .rst_ni       (reset),
    .clr_i        (idle_start),
    .inc_i        (w_beat | a_beat),
    .len_i        (len_q),
    .outer_last_i (outer_last),
    .addr_o       (seq_addr),
    .outer_o      (seq_outer),
    .addr_last_o  (seq_addr_last),
    .wrap_o       (seq_wrap),
    .last_o       (seq_last)
  );

  // Next FSM state; a zero-pass job skips straight to DONE from its entry point.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && len_good) begin
          if (!cfg_reuse)               state_d = ST_LOAD;
          else if (cfg_npass == '0)     state_d = ST_DONE;
          else                          state_d = ST_COMPUTE;
        end
      end
      ST_LOAD: begin
        if (w_beat && seq_wrap && seq_last)
          state_d = (npass_q == '0) ? ST_DONE : ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (a_beat && seq_wrap && seq_last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM register with registered status/ready outputs and the latched job config.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      npass_q   <= '0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_ready_q <= (state_d == ST_LOAD);
      a_ready_q <= (state_d == ST_COMPUTE);
      busy_q    <= (state_d == ST_LOAD) || (state_d == ST_COMPUTE);
      done_q    <= (state_d == ST_DONE);
      cfg_err_q <= idle_start && !len_good;
      if (idle_start && len_good) begin
        len_q   <= cfg_len;
        npass_q <= cfg_npass;
      end
    end
  end

  // Command for the beat accepted this cycle. Idle compute cycles keep the
  // last read address on the bus so the buffer read port does not toggle.
  always_comb begin
    pk_d = '0;
    case (state_q)
      ST_LOAD: begin
        if (w_beat) begin
          pk_d.wrb      = LANE0 << seq_outer;
          pk_d.wrb_addr = seq_addr;
          pk_d.wrb_data = w_data;
        end
      end
      ST_COMPUTE: begin
        if (a_beat) begin
          pk_d.rdb_addr = seq_addr;
          if (seq_addr == '0)     pk_d.PE_state = PE_FIRST;
          else if (seq_addr_last) pk_d.PE_state = PE_LAST;
          else                    pk_d.PE_state = PE_ACC;
        end else begin
          pk_d.rdb_addr = pk_q.rdb_addr;
        end
      end
      default: pk_d = '0;
    endcase
  end

  // Packet output register: one cycle from handshake to decoder.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pk_q <= '0;
    else        pk_q <= pk_d;
  end

  assign w_ready    = w_ready_q;
  assign a_ready    = a_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;
  assign CNN_pk_out = pk_q;
  assign dbg_state  = state_q;

endmodule
